// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a multiplexed active-low 7-seg bus; capture lands STABLE_CYCLES+1 edges after pins settle.
// No backpressure: observes the bus every cycle, outputs are registered level/pulse signals.
module seg7_scan_decoder #(
   parameter int DIGITS        = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DIGITS-1:0]     an,
   input  logic [6:0]            seg,
   output logic [4*DIGITS-1:0]   value,
   output logic [DIGITS-1:0]     digit_ok,
   output logic                  frame_valid,
   output logic                  err
);

   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [DIGITS-1:0]     an_s_q, an_s_d, an_p_q, an_p_d;
   logic [6:0]            seg_s_q, seg_s_d, seg_p_q, seg_p_d;
   logic [DIGITS-1:0]     seen_q, seen_d;
   logic [4*DIGITS-1:0]   value_q, value_d;
   logic [DIGITS-1:0]     digit_ok_q, digit_ok_d;
   logic                  frame_valid_q, frame_valid_d;
   logic                  err_q, err_d;

   function automatic logic multi_low(input logic [DIGITS-1:0] a);
      logic any;
      logic multi;
      any   = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!a[i]) begin
            if (any) multi = 1'b1;
            any = 1'b1;
         end
      end
      return multi;
   endfunction

   // {legal, blank, nibble}; neither flag set means an illegal pattern
   function automatic logic [5:0] decode(input logic [6:0] s);
      case (s)
         7'b1000000: return 6'b10_0000;
         7'b1111001: return 6'b10_0001;
         7'b0100100: return 6'b10_0010;
         7'b0110000: return 6'b10_0011;
         7'b0011001: return 6'b10_0100;
         7'b0010010: return 6'b10_0101;
         7'b0000010: return 6'b10_0110;
         7'b1111000: return 6'b10_0111;
         7'b0000000: return 6'b10_1000;
         7'b0010000: return 6'b10_1001;
         7'b0001000: return 6'b10_1010;
         7'b0000011: return 6'b10_1011;
         7'b1000110: return 6'b10_1100;
         7'b0100001: return 6'b10_1101;
         7'b0000110: return 6'b10_1110;
         7'b0001110: return 6'b10_1111;
         7'b1111111: return 6'b01_0000;
         default:    return 6'b00_0000;
      endcase
   endfunction

   logic              any_low, cur_multi, prev_multi, single, same, capture;
   logic [IDXW-1:0]   idx;
   logic [5:0]        dec;
   logic [DIGITS-1:0] seen_n;

   always_comb begin
      an_s_d        = an;
      seg_s_d       = seg;
      an_p_d        = an_s_q;
      seg_p_d       = seg_s_q;
      state_d       = state_q;
      cnt_d         = cnt_q;
      seen_d        = seen_q;
      value_d       = value_q;
      digit_ok_d    = digit_ok_q;
      frame_valid_d = 1'b0;
      err_d         = 1'b0;
      capture       = 1'b0;
      any_low       = 1'b0;
      idx           = '0;
      seen_n        = seen_q;
      dec           = decode(seg_s_q);

      for (int i = 0; i < DIGITS; i++) begin
         if (!an_s_q[i]) begin
            any_low = 1'b1;
            idx     = IDXW'(i);
         end
      end
      cur_multi  = multi_low(an_s_q);
      prev_multi = multi_low(an_p_q);
      single     = any_low && !cur_multi;
      same       = (an_s_q == an_p_q) && (seg_s_q == seg_p_q);

      // Multiple-anode error fires only when the condition begins
      if (cur_multi && !prev_multi) err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (single) begin
               state_d = TRACK;
               cnt_d   = '0;
            end
         end
         TRACK: begin
            if (!single) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!same) begin
               cnt_d = '0;
            end else if (cnt_q == 8'(STABLE_CYCLES - 2)) begin
               capture = 1'b1;
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HELD: begin
            if (!same) begin
               state_d = single ? TRACK : IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (capture) begin
         seen_n[idx] = 1'b1;
         if (dec[5]) begin
            value_d[idx*4 +: 4] = dec[3:0];
            digit_ok_d[idx]     = 1'b1;
         end else begin
            digit_ok_d[idx] = 1'b0;
            if (!dec[4]) err_d = 1'b1;
         end
         if (&seen_n) begin
            frame_valid_d = 1'b1;
            seen_d        = '0;
         end else begin
            seen_d = seen_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         an_s_q        <= '1;
         seg_s_q       <= '1;
         an_p_q        <= '1;
         seg_p_q       <= '1;
         seen_q        <= '0;
         value_q       <= '0;
         digit_ok_q    <= '0;
         frame_valid_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         an_s_q        <= an_s_d;
         seg_s_q       <= seg_s_d;
         an_p_q        <= an_p_d;
         seg_p_q       <= seg_p_d;
         seen_q        <= seen_d;
         value_q       <= value_d;
         digit_ok_q    <= digit_ok_d;
         frame_valid_q <= frame_valid_d;
         err_q         <= err_d;
      end
   end

   assign value       = value_q;
   assign digit_ok    = digit_ok_q;
   assign frame_valid = frame_valid_q;
   assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: each driven pattern schedules its expected capture/error events by edge number.
module tb_seg7_scan_decoder;
   localparam int DIGITS = 8;
   localparam int ST     = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic [31:0] value;
   logic [7:0]  digit_ok;
   logic        frame_valid;
   logic        err;

   seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(ST)) dut (
      .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
      .value(value), .digit_ok(digit_ok), .frame_valid(frame_valid), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         at;
      int         kind;   // 0 legal, 1 blank, 2 illegal, 3 multi-anode error
      int         dig;
      logic [3:0] nib;
   } ev_t;

   ev_t         sb[$];
   int          checks = 0;
   int          failures = 0;
   int          edge_cnt = 0;
   logic [31:0] exp_value;
   logic [7:0]  exp_ok, seen, prev_an;
   logic        exp_frame, exp_err;
   logic [6:0]  glyph [16];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_cnt, got, exp);
      end
   endtask

   task automatic apply(input ev_t ev);
      if (ev.kind == 3) begin
         exp_err = 1'b1;
      end else begin
         if (ev.kind == 0) begin
            exp_value[ev.dig*4 +: 4] = ev.nib;
            exp_ok[ev.dig]           = 1'b1;
         end else begin
            exp_ok[ev.dig] = 1'b0;
            if (ev.kind == 2) exp_err = 1'b1;
         end
         seen[ev.dig] = 1'b1;
         if (seen == 8'hFF) begin
            exp_frame = 1'b1;
            seen      = 8'h00;
         end
      end
   endtask

   task automatic tick();
      ev_t ev;
      @(posedge clk);
      edge_cnt++;
      exp_frame = 1'b0;
      exp_err   = 1'b0;
      while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
         ev = sb.pop_front();
         apply(ev);
      end
      #1;
      check_val("value", value, exp_value);
      check_val("digit_ok", {24'd0, digit_ok}, {24'd0, exp_ok});
      check_val("frame_valid", {31'd0, frame_valid}, {31'd0, exp_frame});
      check_val("err", {31'd0, err}, {31'd0, exp_err});
   endtask

   function automatic int nlow(input logic [7:0] a);
      int n = 0;
      for (int i = 0; i < 8; i++) if (!a[i]) n++;
      return n;
   endfunction

   task automatic drive(input logic [7:0] a, input logic [6:0] s, input int n);
      ev_t ev;
      int  start;
      start  = edge_cnt + 1;
      ev.dig = 0;
      ev.nib = 4'h0;
      if (nlow(a) == 1 && n >= ST) begin
         for (int i = 0; i < 8; i++) if (!a[i]) ev.dig = i;
         ev.kind = (s == 7'h7F) ? 1 : 2;
         for (int k = 0; k < 16; k++) begin
            if (glyph[k] == s) begin
               ev.kind = 0;
               ev.nib  = 4'(k);
            end
         end
         ev.at = start + ST;
         sb.push_back(ev);
      end
      if (nlow(a) > 1 && nlow(prev_an) <= 1) begin
         ev.kind = 3;
         ev.at   = start + 1;
         sb.push_back(ev);
      end
      prev_an = a;
      an      = a;
      seg     = s;
      repeat (n) tick();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      sb.delete();
      exp_value = '0;
      exp_ok    = '0;
      seen      = '0;
      prev_an   = 8'hFF;
      repeat (n) tick();
   endtask

   initial begin
      logic [31:0] word;
      int          rest [5];
      glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
      glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
      glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
      glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

      an  = 8'h00;
      seg = 7'h7F;
      do_reset(2);
      rst_n = 1'b1;
      drive(8'hFF, 7'h7F, 3);

      // Full scan of one word; frame completes on digit 7
      word = 32'h1234ABCF;
      for (int i = 0; i < 8; i++) drive(~(8'h01 << i), glyph[word[i*4 +: 4]], 10);
      drive(8'hFF, 7'h7F, 3);
      check_val("scan_value", value, 32'h1234ABCF);
      check_val("scan_ok", {24'd0, digit_ok}, 32'h0000_00FF);

      // Too-short holds never capture; a 4-cycle hold captures on the following edge
      drive(8'hFE, glyph[2], 3);
      drive(8'hFE, glyph[5], 2);
      drive(8'hFF, 7'h7F, 3);
      drive(8'hFE, glyph[2], 4);
      drive(8'hFF, 7'h7F, 4);

      // Illegal then blank on digit 3, then multi-anode conditions
      drive(8'hF7, 7'b1010101, 8);
      drive(8'hF7, 7'h7F, 8);
      drive(8'hFC, glyph[8], 6);
      drive(8'hF0, glyph[8], 3);
      drive(8'hFF, 7'h7F, 3);

      // Finish the frame with an illegal glyph so err and frame_valid coincide
      rest = '{1, 2, 4, 5, 6};
      foreach (rest[j]) drive(~(8'h01 << rest[j]), glyph[rest[j] + 8], 6);
      drive(8'h7F, 7'b0101010, 6);
      drive(8'hFF, 7'h7F, 3);

      // Reset in the middle of a count
      drive(8'hDF, glyph[7], 2);
      do_reset(1);
      rst_n = 1'b1;
      drive(8'hDF, glyph[7], 10);
      drive(8'hFF, 7'h7F, 3);
      check_val("final_value", value, 32'h0070_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
